// File: rtl/bps_mc_arb.sv
// Two-requester round-robin arbiter for the shared MC port, with source tagging
// in rdctl, per-requester outstanding-load limits and a 4-entry response FIFO.
module bps_mc_arb #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_BIT         = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req_ld,
  input  logic        r0_req_st,
  input  logic [47:0] r0_req_vadr,
  input  logic [63:0] r0_req_wrd_rdctl,
  output logic        r0_req_stall,
  output logic        r0_rsp_push,
  output logic [31:0] r0_rsp_rdctl,
  output logic [63:0] r0_rsp_data,
  input  logic        r0_rsp_stall,
  input  logic        r1_req_ld,
  input  logic        r1_req_st,
  input  logic [47:0] r1_req_vadr,
  input  logic [63:0] r1_req_wrd_rdctl,
  output logic        r1_req_stall,
  output logic        r1_rsp_push,
  output logic [31:0] r1_rsp_rdctl,
  output logic [63:0] r1_rsp_data,
  input  logic        r1_rsp_stall,
  output logic        mc_req_ld,
  output logic        mc_req_st,
  output logic [47:0] mc_req_vadr,
  output logic [63:0] mc_req_wrd_rdctl,
  input  logic        mc_req_stall,
  input  logic        mc_rsp_push,
  input  logic [31:0] mc_rsp_rdctl,
  input  logic [63:0] mc_rsp_data,
  output logic        mc_rsp_stall
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic        id;
    logic [31:0] rdctl;
    logic [63:0] data;
  } rsp_entry_t;

  logic          last_q, last_d;
  logic [CW-1:0] out0_q, out0_d, out1_q, out1_d;
  logic          mc_req_ld_q, mc_req_ld_d, mc_req_st_q, mc_req_st_d;
  logic [47:0]   mc_req_vadr_q, mc_req_vadr_d;
  logic [63:0]   mc_req_wrd_rdctl_q, mc_req_wrd_rdctl_d;
  rsp_entry_t    fifo_q [4];
  rsp_entry_t    fifo_d [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          mc_rsp_stall_q, mc_rsp_stall_d;
  logic          r0_rsp_push_q, r0_rsp_push_d, r1_rsp_push_q, r1_rsp_push_d;
  logic [31:0]   r0_rsp_rdctl_q, r0_rsp_rdctl_d, r1_rsp_rdctl_q, r1_rsp_rdctl_d;
  logic [63:0]   r0_rsp_data_q, r0_rsp_data_d, r1_rsp_data_q, r1_rsp_data_d;

  logic          elig0, elig1, grant0, grant1;
  logic [31:0]   tag0, tag1, head_rdctl;
  rsp_entry_t    head;
  logic          head_stall, pop, push, full, overflow;

  // A load is held back once its requester has MAX_OUTSTANDING loads in flight.
  assign elig0  = !mc_req_stall && (r0_req_st || (r0_req_ld && (out0_q < MAX_CNT)));
  assign elig1  = !mc_req_stall && (r1_req_st || (r1_req_ld && (out1_q < MAX_CNT)));
  assign grant0 = !rst && elig0 && (!elig1 || last_q);
  assign grant1 = !rst && elig1 && (!elig0 || !last_q);

  assign r0_req_stall = rst || !grant0;
  assign r1_req_stall = rst || !grant1;

  always_comb begin
    tag0          = r0_req_wrd_rdctl[31:0];
    tag0[TAG_BIT] = 1'b0;
    tag1          = r1_req_wrd_rdctl[31:0];
    tag1[TAG_BIT] = 1'b1;
    last_d             = last_q;
    mc_req_ld_d        = 1'b0;
    mc_req_st_d        = 1'b0;
    mc_req_vadr_d      = mc_req_vadr_q;
    mc_req_wrd_rdctl_d = mc_req_wrd_rdctl_q;
    if (grant0) begin
      last_d             = 1'b0;
      mc_req_ld_d        = r0_req_ld;
      mc_req_st_d        = r0_req_st;
      mc_req_vadr_d      = r0_req_vadr;
      mc_req_wrd_rdctl_d = r0_req_ld ? {32'b0, tag0} : r0_req_wrd_rdctl;
    end else if (grant1) begin
      last_d             = 1'b1;
      mc_req_ld_d        = r1_req_ld;
      mc_req_st_d        = r1_req_st;
      mc_req_vadr_d      = r1_req_vadr;
      mc_req_wrd_rdctl_d = r1_req_ld ? {32'b0, tag1} : r1_req_wrd_rdctl;
    end
  end

  // Strict in-order delivery: a stalled head blocks everything behind it.
  assign head       = fifo_q[rd_ptr_q];
  assign head_stall = head.id ? r1_rsp_stall : r0_rsp_stall;
  assign full       = (count_q == 3'd4);
  assign pop        = !rst && (count_q != 3'd0) && !head_stall;
  assign push       = !rst && mc_rsp_push && (!full || pop);
  assign overflow   = !rst && mc_rsp_push && full && !pop;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{id: mc_rsp_rdctl[TAG_BIT], rdctl: mc_rsp_rdctl, data: mc_rsp_data};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    mc_rsp_stall_d = (count_d >= 3'd2);
  end

  always_comb begin
    head_rdctl          = head.rdctl;
    head_rdctl[TAG_BIT] = 1'b0;
    r0_rsp_push_d  = pop && !head.id;
    r1_rsp_push_d  = pop && head.id;
    r0_rsp_rdctl_d = r0_rsp_rdctl_q;
    r0_rsp_data_d  = r0_rsp_data_q;
    r1_rsp_rdctl_d = r1_rsp_rdctl_q;
    r1_rsp_data_d  = r1_rsp_data_q;
    if (r0_rsp_push_d) begin
      r0_rsp_rdctl_d = head_rdctl;
      r0_rsp_data_d  = head.data;
    end
    if (r1_rsp_push_d) begin
      r1_rsp_rdctl_d = head_rdctl;
      r1_rsp_data_d  = head.data;
    end
  end

  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    case ({grant0 && r0_req_ld, r0_rsp_push_d})
      2'b10:   out0_d = out0_q + CW'(1);
      2'b01:   out0_d = out0_q - CW'(1);
      default: out0_d = out0_q;
    endcase
    case ({grant1 && r1_req_ld, r1_rsp_push_d})
      2'b10:   out1_d = out1_q + CW'(1);
      2'b01:   out1_d = out1_q - CW'(1);
      default: out1_d = out1_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q             <= 1'b1;
      out0_q             <= '0;
      out1_q             <= '0;
      mc_req_ld_q        <= 1'b0;
      mc_req_st_q        <= 1'b0;
      mc_req_vadr_q      <= '0;
      mc_req_wrd_rdctl_q <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      mc_rsp_stall_q     <= 1'b0;
      r0_rsp_push_q      <= 1'b0;
      r0_rsp_rdctl_q     <= '0;
      r0_rsp_data_q      <= '0;
      r1_rsp_push_q      <= 1'b0;
      r1_rsp_rdctl_q     <= '0;
      r1_rsp_data_q      <= '0;
    end else begin
      last_q             <= last_d;
      out0_q             <= out0_d;
      out1_q             <= out1_d;
      mc_req_ld_q        <= mc_req_ld_d;
      mc_req_st_q        <= mc_req_st_d;
      mc_req_vadr_q      <= mc_req_vadr_d;
      mc_req_wrd_rdctl_q <= mc_req_wrd_rdctl_d;
      fifo_q             <= fifo_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
      mc_rsp_stall_q     <= mc_rsp_stall_d;
      r0_rsp_push_q      <= r0_rsp_push_d;
      r0_rsp_rdctl_q     <= r0_rsp_rdctl_d;
      r0_rsp_data_q      <= r0_rsp_data_d;
      r1_rsp_push_q      <= r1_rsp_push_d;
      r1_rsp_rdctl_q     <= r1_rsp_rdctl_d;
      r1_rsp_data_q      <= r1_rsp_data_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (overflow) $display("ERROR bps_mc_arb: response pushed into full FIFO, entry dropped at %0t", $time);
  end
`endif

  assign mc_req_ld        = mc_req_ld_q;
  assign mc_req_st        = mc_req_st_q;
  assign mc_req_vadr      = mc_req_vadr_q;
  assign mc_req_wrd_rdctl = mc_req_wrd_rdctl_q;
  assign mc_rsp_stall     = mc_rsp_stall_q;
  assign r0_rsp_push      = r0_rsp_push_q;
  assign r0_rsp_rdctl     = r0_rsp_rdctl_q;
  assign r0_rsp_data      = r0_rsp_data_q;
  assign r1_rsp_push      = r1_rsp_push_q;
  assign r1_rsp_rdctl     = r1_rsp_rdctl_q;
  assign r1_rsp_data      = r1_rsp_data_q;

endmodule
